bht_controller: RTL and testbench

Branch history table controller: owns an array of 2-bit saturating predictor counters and arbitrates its single table port between three requesters. The requesters are fetch-stage lookups, execute-stage resolved-branch updates, and an initialization sweep. Resolved updates are buffered in a small FIFO and drained only in cycles without a lookup. The block sits between the fetch predictor interface and the branch-resolution path.

---
 rtl/bht_pkg.sv | 49 ++++
 rtl/bht_update_fifo.sv | 71 +++++++
 rtl/bht_controller.sv | 154 +++++++++++++++
 tb/tb_bht_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// -----------------------------------------------------------------------------
// bht_pkg
// Shared types and helpers for the branch history table controller.
//   ctr_t    : 2-bit saturating predictor counter (SNT/WNT/WT/ST), MSB = prediction
//   fsm_t    : controller state (INIT sweep, RUN)
//   next_ctr : counter transition for a resolved branch outcome
// -----------------------------------------------------------------------------
package bht_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    // A taken branch from WNT jumps straight to ST and a not-taken branch
    // from WT drops straight to SNT (weak states are not hysteretic).
    function automatic ctr_t next_ctr(input ctr_t state, input logic taken);
        ctr_t nxt;
        nxt = SNT;
        case (state)
            SNT: begin
                if (taken) nxt = WNT;
                else       nxt = SNT;
            end
            WNT: begin
                if (taken) nxt = ST;
                else       nxt = SNT;
            end
            WT: begin
                if (taken) nxt = ST;
                else       nxt = SNT;
            end
            ST: begin
                if (taken) nxt = ST;
                else       nxt = WT;
            end
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bht_update_fifo.sv
// -----------------------------------------------------------------------------
// bht_update_fifo
// Synchronous FIFO holding pending resolved-branch updates {idx, taken}.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (FIFO empties)
//   i_clear        : synchronous clear, wins over push/pop
//   i_push, i_data : write request and entry (ignored when full)
//   i_pop          : remove head (ignored when empty)
//   o_data         : head entry
//   o_full/o_empty : occupancy flags, derived from registered count
// -----------------------------------------------------------------------------
module bht_update_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 7
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(32'd1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(32'd1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == {(PTR_W+1){1'b0}});
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {(PTR_W+1){1'b0}};
        end else if (i_clear) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {(PTR_W+1){1'b0}};
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care while not counted.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/bht_controller.sv
// -----------------------------------------------------------------------------
// bht_controller
// Branch history table of 2-bit saturating counters with a single table port
// shared by fetch lookups (highest priority), buffered resolved-branch updates
// (drained only in lookup-free cycles) and an initialization sweep that writes
// WNT to every entry after reset (and after a flush).
// Optional feature macro: BHT_FLUSH_EN adds i_flush, which restarts the sweep
// and discards pending updates.
// Ports:
//   i_clk, i_rst_n              : clock, asynchronous active-low reset
//   i_flush                     : restart initialization (BHT_FLUSH_EN only)
//   i_lookup_en, i_lookup_idx   : lookup request
//   o_lookup_pred, o_lookup_pvalid : registered prediction, valid one cycle later
//   i_upd_valid, i_upd_idx, i_upd_taken, o_upd_ready : update handshake
//   o_busy                      : initialization sweep in progress
// -----------------------------------------------------------------------------
module bht_controller
    import bht_pkg::*;
#(
    parameter int ENTRIES    = 64,
    parameter int IDX_W      = $clog2(ENTRIES),
    parameter int FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
`ifdef BHT_FLUSH_EN
    input  logic             i_flush,
`endif
    input  logic             i_lookup_en,
    input  logic [IDX_W-1:0] i_lookup_idx,
    output logic             o_lookup_pred,
    output logic             o_lookup_pvalid,
    input  logic             i_upd_valid,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken,
    output logic             o_upd_ready,
    output logic             o_busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);

    fsm_t             r_state;
    fsm_t             w_state_nxt;
    logic [IDX_W-1:0] r_sweep_ptr;
    ctr_t             r_table [ENTRIES];
    logic             r_lookup_pred;
    logic             r_lookup_pvalid;

    logic             w_flush;
    logic             w_init_wr;
    logic             w_lookup_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [IDX_W:0]   w_fifo_head;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_taken;

`ifdef BHT_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_head_idx   = w_fifo_head[IDX_W:1];
    assign w_head_taken = w_fifo_head[0];

    // Depends only on registered state so the handshake has no input-to-output path.
    assign o_upd_ready     = (r_state == RUN) && !w_fifo_full;
    assign o_busy          = (r_state == INIT);
    assign o_lookup_pred   = r_lookup_pred;
    assign o_lookup_pvalid = r_lookup_pvalid;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= INIT;
        else          r_state <= w_state_nxt;
    end

    // Next state and table-port arbitration: sweep, else lookup, else drain.
    always_comb begin
        w_state_nxt   = r_state;
        w_init_wr     = 1'b0;
        w_lookup_fire = 1'b0;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            INIT: begin
                w_init_wr = 1'b1;
                if (w_flush)                       w_state_nxt = INIT;
                else if (r_sweep_ptr == LAST_IDX)  w_state_nxt = RUN;
                else                               w_state_nxt = INIT;
            end
            RUN: begin
                if (w_flush) begin
                    w_state_nxt = INIT;
                end else begin
                    w_state_nxt   = RUN;
                    w_push        = i_upd_valid && !w_fifo_full;
                    w_lookup_fire = i_lookup_en;
                    w_pop         = !i_lookup_en && !w_fifo_empty;
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    // Sweep pointer: wraps back to zero on the last INIT write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_sweep_ptr <= {IDX_W{1'b0}};
        else if (w_flush)            r_sweep_ptr <= {IDX_W{1'b0}};
        else if (r_state == INIT)    r_sweep_ptr <= r_sweep_ptr + IDX_ONE;
        else                         r_sweep_ptr <= {IDX_W{1'b0}};
    end

    // Registered lookup result; invalid after any non-lookup or INIT cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lookup_pred   <= 1'b0;
            r_lookup_pvalid <= 1'b0;
        end else if (w_lookup_fire) begin
            r_lookup_pred   <= r_table[i_lookup_idx][1];
            r_lookup_pvalid <= 1'b1;
        end else begin
            r_lookup_pvalid <= 1'b0;
        end
    end

    // Counter table: deliberately not reset, the INIT sweep establishes contents.
    always_ff @(posedge i_clk) begin
        if (w_init_wr)
            r_table[r_sweep_ptr] <= WNT;
        else if (w_pop)
            r_table[w_head_idx] <= next_ctr(r_table[w_head_idx], w_head_taken);
    end

    bht_update_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (IDX_W + 1)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_flush),
        .i_push  (w_push),
        .i_data  ({i_upd_idx, i_upd_taken}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_bht_controller.sv
module tb_bht_controller;

    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;
    localparam int DEPTH   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             lookup_en;
    logic [IDX_W-1:0] lookup_idx;
    logic             lookup_pred;
    logic             lookup_pvalid;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_ready;
    logic             busy;

    bht_controller #(.ENTRIES(ENTRIES), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
`ifdef BHT_FLUSH_EN
        .i_flush         (flush),
`endif
        .i_lookup_en     (lookup_en),
        .i_lookup_idx    (lookup_idx),
        .o_lookup_pred   (lookup_pred),
        .o_lookup_pvalid (lookup_pvalid),
        .i_upd_valid     (upd_valid),
        .i_upd_idx       (upd_idx),
        .i_upd_taken     (upd_taken),
        .o_upd_ready     (upd_ready),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference model: counters as integers 0..3, pending updates as a queue.
    int m_ctr [ENTRIES];
    int m_q [$];
    int m_init_left;
    int m_ptr;
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_q.delete();
        m_init_left = ENTRIES;
        m_ptr       = 0;
    endtask

    // Saturating counter rule in arithmetic form.
    task automatic m_apply(input int idx, input int tk);
        if (tk != 0) m_ctr[idx] = (m_ctr[idx] == 0) ? 1 : 3;
        else         m_ctr[idx] = (m_ctr[idx] == 3) ? 2 : 0;
    endtask

    // One clock cycle: drive, check handshake state, advance model, check lookup result.
    task automatic do_cycle(input logic le, input int li, input logic uv, input int ui, input logic ut);
        int   exp_pv;
        int   exp_pd;
        int   e;
        logic m_ready;
        lookup_en  = le;
        lookup_idx = IDX_W'(li);
        upd_valid  = uv;
        upd_idx    = IDX_W'(ui);
        upd_taken  = ut;
        m_ready = (m_init_left == 0) && (m_q.size() < DEPTH);
        chk("busy", {31'd0, busy}, {31'd0, (m_init_left > 0)});
        chk("upd_ready", {31'd0, upd_ready}, {31'd0, m_ready});
        exp_pv = 0;
        exp_pd = 0;
        if (m_init_left > 0) begin
            m_ctr[m_ptr] = 1;
            m_ptr = (m_ptr + 1) % ENTRIES;
            m_init_left--;
        end else if (le) begin
            exp_pv = 1;
            exp_pd = (m_ctr[li] >= 2) ? 1 : 0;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_apply(e / 2, e % 2);
        end
        if (uv && m_ready) m_q.push_back(ui * 2 + int'(ut));
        tick();
        chk("pvalid", {31'd0, lookup_pvalid}, exp_pv);
        if (exp_pv != 0) chk("pred", {31'd0, lookup_pred}, exp_pd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    // Runs through INIT, offering traffic that must be ignored, and measures busy length.
    task automatic run_init();
        int busy_cnt;
        busy_cnt = 0;
        for (int c = 0; c < ENTRIES + 4; c++) begin
            if (busy) busy_cnt++;
            do_cycle((c == 10) ? 1'b1 : 1'b0, 3, (c % 7 == 2) ? 1'b1 : 1'b0, 4, 1'b1);
        end
        chk("busy_len", busy_cnt, ENTRIES);
    endtask

    int seq_tk [4] = '{1, 0, 0, 1};
    int seq_pd [4] = '{1, 1, 0, 0};
    int acc;

    initial begin
        rst_n = 1'b0; flush = 1'b0; lookup_en = 1'b0; lookup_idx = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 0;
        #1;
        chk("rst_busy",   {31'd0, busy},          32'd1);
        chk("rst_ready",  {31'd0, upd_ready},     32'd0);
        chk("rst_pvalid", {31'd0, lookup_pvalid}, 32'd0);
        chk("rst_pred",   {31'd0, lookup_pred},   32'd0);
        tick(); tick();
        rst_n = 1'b1;
        m_reset();
        run_init();

        // Freshly initialized entries predict not-taken.
        do_cycle(1'b1, 0, 1'b0, 0, 1'b0);
        chk("init_pred0", {31'd0, lookup_pred}, 32'd0);
        do_cycle(1'b1, 31, 1'b0, 0, 1'b0);
        chk("init_pred31", {31'd0, lookup_pred}, 32'd0);
        do_cycle(1'b1, 63, 1'b0, 0, 1'b0);
        chk("init_pred63", {31'd0, lookup_pred}, 32'd0);

        // Train index 5: T->ST, N->WT, N->SNT, T->WNT.
        for (int k = 0; k < 4; k++) begin
            do_cycle(1'b0, 0, 1'b1, 5, seq_tk[k] != 0);
            idle(1);
            do_cycle(1'b1, 5, 1'b0, 0, 1'b0);
            chk("idx5_seq", {31'd0, lookup_pred}, seq_pd[k]);
        end

        // Earliest visibility: accept at t, drain at t+1, lookup at t+2.
        do_cycle(1'b0, 0, 1'b1, 9, 1'b1);
        do_cycle(1'b0, 0, 1'b0, 0, 1'b0);
        do_cycle(1'b1, 9, 1'b0, 0, 1'b0);
        chk("idx9_visible", {31'd0, lookup_pred}, 32'd1);

        // Fill FIFO under continuous lookups: exactly DEPTH accepted.
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (upd_ready) acc++;
            do_cycle(1'b1, i, 1'b1, 20 + (i % 2), (i % 3) != 0);
        end
        chk("fifo_acc", acc, DEPTH);
        do_cycle(1'b1, 20, 1'b0, 0, 1'b0);
        chk("stall_full", {31'd0, upd_ready}, 32'd0);
        idle(5);
        do_cycle(1'b1, 20, 1'b0, 0, 1'b0);
        do_cycle(1'b1, 21, 1'b0, 0, 1'b0);

        // Randomized traffic on a small index set to collide updates and lookups.
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, $urandom_range(0, 7),
                     ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, $urandom_range(0, 7),
                     ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
        end
        idle(6);

`ifdef BHT_FLUSH_EN
        // Train 7 to ST, queue two updates, then flush.
        do_cycle(1'b0, 0, 1'b1, 7, 1'b1);
        do_cycle(1'b0, 0, 1'b1, 7, 1'b1);
        idle(3);
        do_cycle(1'b1, 7, 1'b0, 0, 1'b0);
        chk("idx7_trained", {31'd0, lookup_pred}, 32'd1);
        do_cycle(1'b1, 7, 1'b1, 7, 1'b1);
        do_cycle(1'b1, 7, 1'b1, 7, 1'b1);
        lookup_en = 1'b0; upd_valid = 1'b0; flush = 1'b1;
        m_reset();
        tick();
        flush = 1'b0;
        run_init();
        do_cycle(1'b1, 7, 1'b0, 0, 1'b0);
        chk("flush_idx7", {31'd0, lookup_pred}, 32'd0);
`endif

        // Asynchronous reset in the middle of a drain with a valid lookup result out.
        do_cycle(1'b0, 0, 1'b1, 11, 1'b1);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 11, 1'b1, 11, 1'b1);
        do_cycle(1'b0, 0, 1'b0, 0, 1'b0);
        do_cycle(1'b1, 11, 1'b0, 0, 1'b0);
        do_cycle(1'b0, 0, 1'b0, 0, 1'b0);
        lookup_en = 1'b1; lookup_idx = IDX_W'(11);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",   {31'd0, busy},          32'd1);
        chk("arst_ready",  {31'd0, upd_ready},     32'd0);
        chk("arst_pvalid", {31'd0, lookup_pvalid}, 32'd0);
        chk("arst_pred",   {31'd0, lookup_pred},   32'd0);
        lookup_en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        m_reset();
        run_init();
        do_cycle(1'b1, 11, 1'b0, 0, 1'b0);
        chk("arst_idx11", {31'd0, lookup_pred}, 32'd0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
